// File: rtl/uart_pkg.sv
// Shared UART constants and byte-FSM state encoding (receiver and transmitter).
package uart_pkg;

   localparam int CLK_FS       = 24_000_000;
   localparam int UART_BPS     = 460_800;
   localparam int BPS_CNT      = CLK_FS / UART_BPS;   // 52 clocks per bit
   localparam int FRAME_BYTES  = 11;
   localparam int FRAME_W      = 8 * FRAME_BYTES;
   localparam int TIMEOUT_BITS = 20;

   // The synchroniser and edge register put the FSM a few clocks behind the
   // wire. START is entered with clk_cnt already advanced by this amount, so
   // the mid-bit sample sits early enough to land inside the half-length
   // stop bit that our transmitter sends between back-to-back bytes.
   localparam int SYNC_LAT     = 3;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } rx_state_t;

endpackage

// File: rtl/uart_frame_receiver_if.sv
// Serial input and frame-level outputs of the UART frame receiver.
interface uart_frame_receiver_if;
   import uart_pkg::*;

   logic               rxd;
   logic [FRAME_W-1:0] rx_data;
   logic               rx_done;
   logic               frame_err;
   logic               rx_busy;

   // master: the receiver; slave: the line driver / consuming logic
   modport master (
      input  rxd,
      output rx_data,
      output rx_done,
      output frame_err,
      output rx_busy
   );

   modport slave (
      output rxd,
      input  rx_data,
      input  rx_done,
      input  frame_err,
      input  rx_busy
   );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte deserialiser: synchroniser, start-edge detect, byte FSM.
// byte_valid_o / stop_err_o are single-cycle pulses in the stop-sample cycle.
module uart_rx_byte
   import uart_pkg::*;
(
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       rxd_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   output logic       stop_err_o,
   output logic       start_o,
   output logic       busy_o
);

   localparam int               CNT_W     = $clog2(BPS_CNT);
   localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(BPS_CNT / 2);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BPS_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_ENTRY = CNT_W'(SYNC_LAT);

   logic             rxd_meta_q;
   logic             rxd_sync_q;
   logic             rxd_prev_q;
   logic             start_edge;

   rx_state_t        state_q, state_d;
   logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             cnt_mid;
   logic             cnt_last;
   logic [CNT_W-1:0] cnt_wrap;

   // two-flop synchroniser plus a delayed copy for falling-edge detection
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rxd_meta_q <= 1'b1;
         rxd_sync_q <= 1'b1;
         rxd_prev_q <= 1'b1;
      end else begin
         rxd_meta_q <= rxd_i;
         rxd_sync_q <= rxd_meta_q;
         rxd_prev_q <= rxd_sync_q;
      end
   end

   assign start_edge = rxd_prev_q & ~rxd_sync_q;
   assign cnt_mid    = (clk_cnt_q == CNT_MID);
   assign cnt_last   = (clk_cnt_q == CNT_LAST);
   assign cnt_wrap   = cnt_last ? '0 : clk_cnt_q + 1'b1;

   // byte FSM state, bit counter and shift register
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= IDLE;
         clk_cnt_q <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
      end
   end

   // next-state and per-cycle strobes of the byte FSM
   always_comb begin
      state_d      = state_q;
      clk_cnt_d    = clk_cnt_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      byte_valid_o = 1'b0;
      stop_err_o   = 1'b0;
      start_o      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_edge) begin
               start_o   = 1'b1;
               state_d   = START;
               clk_cnt_d = CNT_ENTRY;
            end
         end
         START: begin
            clk_cnt_d = cnt_wrap;
            if (cnt_mid && rxd_sync_q) begin
               // glitch, not a start bit
               state_d   = IDLE;
               clk_cnt_d = '0;
            end else if (cnt_last) begin
               state_d   = DATA;
               bit_idx_d = '0;
            end
         end
         DATA: begin
            clk_cnt_d = cnt_wrap;
            if (cnt_mid) begin
               shift_d = {rxd_sync_q, shift_q[7:1]};
            end
            if (cnt_last) begin
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end
         end
         STOP: begin
            clk_cnt_d = cnt_wrap;
            if (cnt_mid) begin
               clk_cnt_d = '0;
               if (rxd_sync_q) begin
                  // leave at mid-bit so a shortened stop bit still rearms in time
                  byte_valid_o = 1'b1;
                  state_d      = IDLE;
               end else begin
                  stop_err_o = 1'b1;
                  state_d    = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            clk_cnt_d = '0;
            if (rxd_sync_q) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d   = IDLE;
            clk_cnt_d = '0;
         end
      endcase
   end

   assign byte_o = shift_q;
   assign busy_o = (state_q != IDLE);

endmodule

// File: rtl/uart_frame_receiver.sv
// Packs FRAME_BYTES received bytes (first byte in [7:0]) into one word,
// publishes it with an rx_done strobe, and drops partial frames on a stop-bit
// error or an inter-byte idle timeout (frame_err strobe).
module uart_frame_receiver
   import uart_pkg::*;
(
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   uart_frame_receiver_if.master rx_if
);

   localparam int               IDX_W    = $clog2(FRAME_BYTES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BYTES - 1);
   localparam int               TO_LIMIT = TIMEOUT_BITS * BPS_CNT;
   localparam int               TO_W     = $clog2(TO_LIMIT);
   localparam logic [TO_W-1:0]  TO_END   = TO_W'(TO_LIMIT - 1);

   logic [7:0]             rx_byte;
   logic                   byte_valid;
   logic                   stop_err;
   logic                   start_seen;
   logic                   byte_busy;

   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [FRAME_W-1:0]     shadow_q, shadow_d;
   logic [FRAME_W-1:0]     rx_data_q, rx_data_d;
   logic                   rx_done_q, rx_done_d;
   logic                   frame_err_q, frame_err_d;
   logic [TO_W-1:0]        idle_cnt_q, idle_cnt_d;
   logic [FRAME_BYTES-1:0] lane_we;
   logic                   to_run;

   uart_rx_byte u_rx_byte (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .rxd_i        (rx_if.rxd),
      .byte_o       (rx_byte),
      .byte_valid_o (byte_valid),
      .stop_err_o   (stop_err),
      .start_o      (start_seen),
      .busy_o       (byte_busy)
   );

   // one write lane per byte slot of the shadow word
   for (genvar gi = 0; gi < FRAME_BYTES; gi++) begin : g_lane
      assign lane_we[gi]            = byte_valid && (idx_q == IDX_W'(gi));
      assign shadow_d[8*gi +: 8]    = lane_we[gi] ? rx_byte : shadow_q[8*gi +: 8];
   end

   assign to_run = !byte_busy && (idx_q != '0);

   // frame index, output word, strobes and idle timeout
   always_comb begin
      idx_d       = idx_q;
      rx_data_d   = rx_data_q;
      rx_done_d   = 1'b0;
      frame_err_d = 1'b0;
      idle_cnt_d  = '0;

      if (!start_seen && to_run) begin
         idle_cnt_d = idle_cnt_q + 1'b1;
      end

      if (byte_valid) begin
         if (idx_q == IDX_LAST) begin
            rx_data_d = shadow_d;
            rx_done_d = 1'b1;
            idx_d     = '0;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end else if (stop_err) begin
         idx_d       = '0;
         frame_err_d = 1'b1;
      end else if (to_run && (idle_cnt_q == TO_END)) begin
         idx_d       = '0;
         frame_err_d = 1'b1;
         idle_cnt_d  = '0;
      end
   end

   // frame-level state registers
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         idx_q       <= '0;
         shadow_q    <= '0;
         rx_data_q   <= '0;
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
         idle_cnt_q  <= '0;
      end else begin
         idx_q       <= idx_d;
         shadow_q    <= shadow_d;
         rx_data_q   <= rx_data_d;
         rx_done_q   <= rx_done_d;
         frame_err_q <= frame_err_d;
         idle_cnt_q  <= idle_cnt_d;
      end
   end

   assign rx_if.rx_data   = rx_data_q;
   assign rx_if.rx_done   = rx_done_q;
   assign rx_if.frame_err = frame_err_q;
   assign rx_if.rx_busy   = byte_busy | (idx_q != '0);

endmodule
